// File: rtl/matmul_seq_ctrl_if.sv
// Operand/result stream bundle for the 3x3 matrix-multiply sequencer.
// The master drives operands and consumes results; the slave is the controller.
interface matmul_seq_ctrl_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// 3x3 unsigned matrix multiply on one shared MAC: load 18 words, run 27 MACs, drain 9 results.
// Define MATMUL_SAT_EN to clamp every accumulation step instead of wrapping modulo 2^DW.
module matmul_seq_ctrl #(
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    matmul_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t          state;
    logic [4:0]      load_cnt;
    logic [1:0]      i;
    logic [1:0]      j;
    logic [1:0]      k;
    logic [3:0]      idx;
    logic [DW-1:0]   acc;

    // Operand store: A in entries 0..8, B in 9..17, both row-major.
    logic [DW-1:0]   opnd [0:17];
    logic [DW-1:0]   res  [0:8];

    logic [4:0]      a_idx;
    logic [4:0]      b_idx;
    logic [3:0]      r_idx;
    logic [3:0]      idx_nxt;
    logic [2*DW-1:0] prod;
    logic [2*DW:0]   sum;
    logic [DW-1:0]   acc_nxt;

    function automatic logic [DW-1:0] reduce(input logic [2*DW:0] s);
`ifdef MATMUL_SAT_EN
        if (s > (2*DW+1)'({DW{1'b1}}))
            return {DW{1'b1}};
        return s[DW-1:0];
`else
        return DW'(s);
`endif
    endfunction

    assign a_idx   = 5'(i) * 5'd3 + 5'(k);
    assign b_idx   = 5'd9 + 5'(k) * 5'd3 + 5'(j);
    assign r_idx   = 4'(i) * 4'd3 + 4'(j);
    assign idx_nxt = idx + 4'd1;
    assign prod    = (2*DW)'(opnd[a_idx]) * (2*DW)'(opnd[b_idx]);
    assign sum     = (2*DW+1)'(prod) + ((k == 2'd0) ? '0 : (2*DW+1)'(acc));
    assign acc_nxt = reduce(sum);

    always_ff @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready)
            opnd[load_cnt] <= bus.in_data;
        if (rst_n && state == COMPUTE && k == 2'd2)
            res[r_idx] <= acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= LOAD;
            load_cnt     <= '0;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            idx          <= '0;
            acc          <= '0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (load_cnt == 5'd17) begin
                            load_cnt     <= '0;
                            state        <= COMPUTE;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                        end else begin
                            load_cnt <= load_cnt + 5'd1;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= acc_nxt;
                    if (k == 2'd2) begin
                        k <= '0;
                        if (j == 2'd2) begin
                            j <= '0;
                            if (i == 2'd2) begin
                                // R22 lands this edge; draining starts from R00, written long ago.
                                i             <= '0;
                                state         <= DRAIN;
                                bus.busy      <= 1'b0;
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= res[0];
                                bus.out_last  <= 1'b0;
                                idx           <= '0;
                            end else begin
                                i <= i + 2'd1;
                            end
                        end else begin
                            j <= j + 2'd1;
                        end
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (idx == 4'd8) begin
                            state         <= LOAD;
                            idx           <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                        end else begin
                            idx          <= idx_nxt;
                            bus.out_data <= res[idx_nxt];
                            bus.out_last <= (idx_nxt == 4'd8);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencing controller for 3x3 matrix multiplication over a single shared 16x16 multiply-accumulate unit. It accepts the 18 operand words as a valid/ready stream and runs the 27 MACs one per cycle. It then streams the 9 result words out with valid/ready. It replaces the fully parallel 9-word-wide multiplier where port count and multiplier count must be minimised.

## Interface
- DW, 16, operand/result width (unsigned)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operand beat valid
- in_ready  out  1  controller accepts operand beat
- in_data  in  DW  operand word
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result beat
- out_data  out  DW  result word
- out_last  out  1  high with R22 beat
- busy  out  1  high during COMPUTE

## Operation
- States: LOAD, COMPUTE, DRAIN.
- **LOAD:**
  - in_ready=1.
  - Beat accepted on in_valid && in_ready.
  - Load order: A00,A01,A02,A10..A22, then B00..B22 (row-major, A first).
  - 5-bit load counter 0..17; the 18th accepted beat moves to COMPUTE.
- **COMPUTE:**
  - Counters i,j,k nested with k fastest, then j, then i.
  - Each cycle: acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - At k==2 the updated acc is written to R[i][j].
  - After i=j=k=2 the state moves to DRAIN.
  - in_ready=0; beats offered are not accepted and not stored.
- **DRAIN:**
  - out_valid=1; out_data=R[idx], with idx 0..8 in row-major order.
  - out_last=1 when idx==8.
  - idx advances on out_valid && out_ready.
  - The handshake on idx 8 returns the state to LOAD with all counters zero.
- **Arithmetic:**
  - The product is formed at 2*DW bits, summed with acc at 2*DW+1 bits, then reduced to DW (see Configuration).
  - Results are unsigned.
- **Reset:**
  - When rst_n is low at a clock edge: state=LOAD, all counters 0, acc 0, out_data 0, out_valid 0, out_last 0, busy 0, in_ready 1.
  - A/B/R storage is not cleared.
  - A reset mid-LOAD, mid-COMPUTE or mid-DRAIN abandons the operation; partial operands and results are discarded.

## Timing
- in_ready, out_valid, out_last and busy decode registered state only; there is no combinational path from in_valid or out_ready.
- The 18th accepted beat at edge N puts COMPUTE in effect from N+1.
- COMPUTE lasts exactly 27 cycles with busy=1.
- out_valid first rises 27 cycles after COMPUTE entry.
- Minimum input-to-first-output latency is 28 cycles after the final operand beat. Full-rate total is 18 + 27 + 9 = 54 cycles per matrix.
- While out_valid=1 && out_ready=0, out_data and out_last hold stable.
- The cycle after the last DRAIN handshake, in_ready=1; back-to-back matrices have zero idle cycles.
- in_valid gaps during LOAD stall the counter with no side effects.

## Configuration
- Macro MATMUL_SAT_EN.
- **Defined:** each accumulation step clamps to 2^DW-1 if the full-width sum exceeds it; a clamped acc stays clamped for the remaining k of that element.
- **Undefined:** each accumulation step truncates to the low DW bits (wrap modulo 2^DW), matching the existing parallel multiplier.

## Test plan
- **Identity:** A=identity, B=1..9 with out_ready=1 -> out_data 1,2,...,9 on consecutive cycles, out_last only on 9, in_ready=1 on the following cycle.
- **Uniform:** A all 2, B all 3 -> all 9 results 18. busy is high for exactly 27 cycles, and the first out_valid is 28 cycles after the last operand beat.
- **Overflow:**
  - A00=A01=A02=16'h0100, B00=B10=B20=16'h0100, all other operands 0.
  - R00 = 16'h0000 without MATMUL_SAT_EN; 16'hFFFF with it.
  - All other results are 0 in both builds.
- **Backpressure:** in_valid toggles every cycle during LOAD, and out_ready toggles every cycle during DRAIN. Expect identical results to the Uniform case, out_data held while stalled, no beat lost or duplicated.
- **Ignored input:** in_valid=1 with data 16'hDEAD held throughout COMPUTE and DRAIN -> in_ready=0 throughout, and the next matrix loads correctly from its first beat.
- **Reset mid-op:** rst_n low for one edge at COMPUTE cycle 10 -> next cycle busy=0, in_ready=1, out_valid=0. A fresh Identity load then produces 1..9.
